// File: rtl/regfile_dump_unit.sv
// Walks every register of an external register file through its combinational
// read port and streams each entry out over a valid/ready interface.
module regfile_dump_unit #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned REG_DEPTH  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_arstn,
    input  logic                  i_start,
    input  logic                  i_abort,
    output logic [ADDR_WIDTH-1:0] o_rf_addr,
    input  logic [DATA_WIDTH-1:0] i_rf_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [ADDR_WIDTH-1:0] o_data_addr,
    output logic                  o_busy,
    output logic                  o_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(REG_DEPTH - 1);

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_index;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [ADDR_WIDTH-1:0]   r_data_addr;
    logic                    r_valid;
    logic                    r_busy;
    logic                    r_done;
    logic                    w_handshake;

    assign w_handshake = r_valid & i_ready;

    // Control FSM; valid/busy/done are registered alongside the state
    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            r_state     <= S_IDLE;
            r_index     <= '0;
            r_data      <= '0;
            r_data_addr <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state <= S_READ;
                        r_index <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_READ: begin
                    if (i_abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_data      <= i_rf_data;
                        r_data_addr <= r_index;
                        r_valid     <= 1'b1;
                        r_state     <= S_SEND;
                    end
                end
                S_SEND: begin
                    // Abort takes priority over a coincident handshake
                    if (i_abort) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (w_handshake) begin
                        r_valid <= 1'b0;
                        if (r_index == LAST_IDX) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_index <= r_index + 1'b1;
                            r_state <= S_READ;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_rf_addr   = r_index;
    assign o_valid     = r_valid;
    assign o_data      = r_data;
    assign o_data_addr = r_data_addr;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

// File: tb/tb_regfile_dump_unit.sv
// Directed bench for regfile_dump_unit: full dumps, back-pressure, abort,
// ignored restart, and asynchronous reset mid-dump.
module tb_regfile_dump_unit;

    localparam int unsigned DW    = 64;
    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 32;

    logic          i_clk;
    logic          i_arstn;
    logic          i_start;
    logic          i_abort;
    logic [AW-1:0] o_rf_addr;
    logic [DW-1:0] i_rf_data;
    logic          o_valid;
    logic          i_ready;
    logic [DW-1:0] o_data;
    logic [AW-1:0] o_data_addr;
    logic          o_busy;
    logic          o_done;

    int errors = 0;
    int checks = 0;

    regfile_dump_unit #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .REG_DEPTH  (DEPTH)
    ) dut (
        .i_clk       (i_clk),
        .i_arstn     (i_arstn),
        .i_start     (i_start),
        .i_abort     (i_abort),
        .o_rf_addr   (o_rf_addr),
        .i_rf_data   (i_rf_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_data      (o_data),
        .o_data_addr (o_data_addr),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Preloaded register file: reg[k] = k * 0x1111
    assign i_rf_data = 64'(o_rf_addr) * 64'h1111;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 64'(o_valid), 64'd0);
        chk({tag, "_done"},  64'(o_done),  64'd0);
        chk({tag, "_busy"},  64'(o_busy),  64'd0);
        chk({tag, "_data"},  o_data,       64'd0);
        chk({tag, "_daddr"}, 64'(o_data_addr), 64'd0);
        chk({tag, "_rfaddr"}, 64'(o_rf_addr),  64'd0);
    endtask

    // Pulse i_start across one rising edge; returns at the following falling edge
    task automatic pulse_start();
        i_start = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    // Drives one dump after the start edge. Edge e=1 is the first edge after the
    // start edge. Every cycle with o_valid high checks the beat against the next
    // expected index, which also proves stability while stalled.
    task automatic run_dump(input bit rnd, input int abort_at, input int start_at,
                            input int rst_at, output int beats, output int dones,
                            output int done_e);
        bit hs;
        bit finished;
        beats    = 0;
        dones    = 0;
        done_e   = -1;
        finished = 1'b0;
        for (int e = 1; e <= 400 && !finished; e++) begin
            i_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (o_valid) begin
                chk("beat_addr", 64'(o_data_addr), 64'(beats));
                chk("beat_data", o_data, 64'(beats) * 64'h1111);
                if (beats == abort_at) i_abort = 1'b1;
                if (beats == start_at) i_start = 1'b1;
                if (beats == rst_at) begin
                    #2 i_arstn = 1'b0;
                    #1 chk_all_zero("async_rst");
                    @(posedge i_clk);
                    @(negedge i_clk);
                    i_arstn  = 1'b1;
                    finished = 1'b1;
                end
            end
            if (!finished) begin
                hs = o_valid && i_ready;
                @(posedge i_clk);
                @(negedge i_clk);
                i_abort = 1'b0;
                i_start = 1'b0;
                if (hs) beats++;
                if (o_done) begin
                    dones++;
                    done_e = e;
                    chk("done_rf_addr_no_wrap", 64'(o_rf_addr), 64'(DEPTH - 1));
                    chk("done_valid_low", 64'(o_valid), 64'd0);
                end
                if (!o_busy) finished = 1'b1;
            end
        end
        if (!finished) begin
            checks++;
            errors++;
            $error("FAIL dump_timeout: observed=busy expected=idle within 400 cycles");
        end
    endtask

    initial begin
        int beats, dones, done_e;
        i_arstn = 1'b0;
        i_start = 1'b0;
        i_abort = 1'b0;
        i_ready = 1'b0;
        #12;
        chk_all_zero("reset");
        @(negedge i_clk);
        i_arstn = 1'b1;
        @(negedge i_clk);
        chk("idle_after_release", 64'(o_busy), 64'd0);

        // Abort while idle has no effect
        i_abort = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_abort = 1'b0;
        chk("abort_idle_busy", 64'(o_busy), 64'd0);

        // Full dump, ready tied high
        pulse_start();
        chk("read_busy", 64'(o_busy), 64'd1);
        chk("read_valid", 64'(o_valid), 64'd0);
        chk("read_rf_addr", 64'(o_rf_addr), 64'd0);
        run_dump(1'b0, -1, -1, -1, beats, dones, done_e);
        chk("A_beats", 64'(beats), 64'd32);
        chk("A_dones", 64'(dones), 64'd1);
        // done seen after the 64th edge following the start edge (65th cycle)
        chk("A_done_latency", 64'(done_e), 64'd64);
        chk("A_idle_busy", 64'(o_busy), 64'd0);

        // Random back-pressure
        pulse_start();
        run_dump(1'b1, -1, -1, -1, beats, dones, done_e);
        chk("B_beats", 64'(beats), 64'd32);
        chk("B_dones", 64'(dones), 64'd1);

        // Abort during beat 10 with ready high: beat 10 consumed, no done
        pulse_start();
        run_dump(1'b0, 10, -1, -1, beats, dones, done_e);
        chk("C_beats", 64'(beats), 64'd11);
        chk("C_dones", 64'(dones), 64'd0);
        chk("C_valid_low", 64'(o_valid), 64'd0);
        chk("C_busy_low", 64'(o_busy), 64'd0);

        // Fresh start after abort dumps from address 0; start+abort together in idle
        i_abort = 1'b1;
        pulse_start();
        i_abort = 1'b0;
        chk("D_start_with_abort_busy", 64'(o_busy), 64'd1);
        run_dump(1'b0, -1, -1, -1, beats, dones, done_e);
        chk("D_beats", 64'(beats), 64'd32);
        chk("D_dones", 64'(dones), 64'd1);

        // Start pulsed at beat 5 is ignored
        pulse_start();
        run_dump(1'b0, -1, 5, -1, beats, dones, done_e);
        chk("E_beats", 64'(beats), 64'd32);
        chk("E_dones", 64'(dones), 64'd1);
        @(posedge i_clk);
        @(negedge i_clk);
        chk("E_no_restart", 64'(o_busy), 64'd0);

        // Asynchronous reset during beat 20, then stays idle without start
        pulse_start();
        run_dump(1'b0, -1, -1, 20, beats, dones, done_e);
        chk("F_beats", 64'(beats), 64'd20);
        chk("F_dones", 64'(dones), 64'd0);
        for (int k = 0; k < 4; k++) begin
            @(posedge i_clk);
            @(negedge i_clk);
        end
        chk_all_zero("F_idle");

        // Dump still works after reset
        pulse_start();
        run_dump(1'b0, -1, -1, -1, beats, dones, done_e);
        chk("G_beats", 64'(beats), 64'd32);
        chk("G_done_latency", 64'(done_e), 64'd64);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
